// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage in front of the ALU. It decodes the instruction word,
// reads the local 4x16 register file with write-through bypass from
// writeback, and hands operands downstream through a 2-entry skid buffer.
module alu_operand_fetch #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_instr_valid,
  output logic                        o_instr_ready,
  input  logic [15:0]                 i_instr,
  input  logic                        i_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [3:0]                  o_opcode,
  output logic                        o_shift_dir,
  output logic [DATA_W-1:0]           o_data1,
  output logic [DATA_W-1:0]           o_data2,
  output logic [$clog2(NUM_REGS)-1:0] o_dest
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned OP_W   = 4;

  // Skid-buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic              shift_dir;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [ADDR_W-1:0] dest;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  entry_t            out_q, out_d;
  entry_t            skid_q, skid_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              accept_c;
  logic              consume_c;
  logic [ADDR_W-1:0] ra_c;
  logic [ADDR_W-1:0] rb_c;
  logic              imm_sel_c;
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;
  entry_t            dec_c;

  assign accept_c  = i_instr_valid & ready_q;
  assign consume_c = valid_q & i_ready;

  // Field extraction and register read with bypass from the writeback port
  always_comb begin
    ra_c      = ADDR_W'(i_instr[9:8]);
    rb_c      = ADDR_W'(i_instr[1:0]);
    imm_sel_c = i_instr[11];
    rd1_c     = rf_q[ra_c];
    rd2_c     = rf_q[rb_c];
    if (i_wr_en && (i_wr_addr == ra_c)) rd1_c = i_wr_data;
    if (i_wr_en && (i_wr_addr == rb_c)) rd2_c = i_wr_data;
    dec_c.opcode    = OP_W'(i_instr[15:12]);
    dec_c.shift_dir = i_instr[10];
    dec_c.data1     = rd1_c;
    dec_c.data2     = imm_sel_c ? DATA_W'(i_instr[7:0]) : rd2_c;
    dec_c.dest      = ra_c;
  end

  // Skid-buffer next state and entry movement
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          out_d   = dec_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_c && consume_c) begin
          out_d = dec_c;
        end else if (accept_c) begin
          skid_d  = dec_c;
          state_d = ST_FULL;
        end else if (consume_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume_c) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  // State, handshake flags and held entries
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Register file, written by writeback regardless of handshake state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (i_wr_en) begin
      rf_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_valid       = valid_q;
  assign o_instr_ready = ready_q;
  assign o_opcode      = out_q.opcode;
  assign o_shift_dir   = out_q.shift_dir;
  assign o_data1       = out_q.data1;
  assign o_data2       = out_q.data2;
  assign o_dest        = out_q.dest;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed scenarios plus random traffic,
// checked against a queue-based model of the stage.
module tb_alu_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        valid;
  logic        ready;
  logic [3:0]  opcode;
  logic        shift_dir;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [1:0]  dest;

  alu_operand_fetch dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_instr_valid(instr_valid),
    .o_instr_ready(instr_ready),
    .i_instr      (instr),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_opcode     (opcode),
    .o_shift_dir  (shift_dir),
    .o_data1      (data1),
    .o_data2      (data2),
    .o_dest       (dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        sd;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [1:0]  dst;
  } exp_t;

  exp_t        mq[$];
  logic [15:0] mrf [4];
  logic [3:0]  seen[$];
  int          n_cmp;
  int          n_bad;
  logic        last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: model registers plus writeback forwarding
  function automatic exp_t decode(input logic [15:0] ins);
    exp_t e;
    int   ra;
    int   rb;
    ra    = int'(ins[9:8]);
    rb    = int'(ins[1:0]);
    e.op  = ins[15:12];
    e.sd  = ins[10];
    e.dst = ins[9:8];
    e.d1  = (wr_en && int'(wr_addr) == ra) ? wr_data : mrf[ra];
    if (ins[11]) e.d2 = {8'h00, ins[7:0]};
    else         e.d2 = (wr_en && int'(wr_addr) == rb) ? wr_data : mrf[rb];
    return e;
  endfunction

  task automatic compare_outputs();
    check("o_valid", 32'(valid), 32'(mq.size() > 0));
    check("o_instr_ready", 32'(instr_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      check("o_opcode", 32'(opcode), 32'(mq[0].op));
      check("o_shift_dir", 32'(shift_dir), 32'(mq[0].sd));
      check("o_data1", 32'(data1), 32'(mq[0].d1));
      check("o_data2", 32'(data2), 32'(mq[0].d2));
      check("o_dest", 32'(dest), 32'(mq[0].dst));
    end
  endtask

  // One clock: predict with pre-edge inputs, update model, compare after edge
  task automatic step();
    logic acc;
    logic con;
    exp_t e;
    acc = instr_valid && (mq.size() < 2);
    con = (mq.size() > 0) && ready;
    e   = decode(instr);
    if (valid && ready) seen.push_back(opcode);
    @(posedge clk);
    #1;
    if (con) mq.delete(0);
    if (acc) mq.push_back(e);
    if (wr_en) mrf[wr_addr] = wr_data;
    last_acc = acc;
    compare_outputs();
  endtask

  task automatic set_instr(input logic [3:0] op, input logic imm, input logic sd,
                           input logic [1:0] ra, input logic [7:0] low);
    instr_valid = 1'b1;
    instr       = {op, imm, sd, ra, low};
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) mrf[i] = 16'h0;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    last_acc    = 1'b0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0;
    wr_en       = 1'b0;
    wr_addr     = 2'd0;
    wr_data     = 16'h0;
    ready       = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    check("rst_data1", 32'(data1), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(instr_ready), 32'h1);

    // Basic register read
    write_reg(2'd1, 16'h1234);
    write_reg(2'd2, 16'h0F0F);
    ready = 1'b1;
    set_instr(4'h0, 1'b0, 1'b0, 2'd1, 8'd2);
    step();
    instr_valid = 1'b0;
    check("basic_valid", 32'(valid), 32'h1);
    check("basic_data1", 32'(data1), 32'h1234);
    check("basic_data2", 32'(data2), 32'h0F0F);
    check("basic_dest", 32'(dest), 32'h1);
    step();

    // Immediate operand
    write_reg(2'd3, 16'h00FF);
    set_instr(4'h7, 1'b1, 1'b1, 2'd3, 8'h04);
    step();
    instr_valid = 1'b0;
    check("imm_data1", 32'(data1), 32'h00FF);
    check("imm_data2", 32'(data2), 32'h0004);
    check("imm_shift", 32'(shift_dir), 32'h1);
    step();

    // Bypass on source 1
    set_instr(4'h5, 1'b0, 1'b0, 2'd0, 8'd1);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hBEEF;
    step();
    instr_valid = 1'b0; wr_en = 1'b0;
    check("bypass_data1", 32'(data1), 32'hBEEF);
    step();

    // Writeback colliding with both sources
    set_instr(4'h6, 1'b0, 1'b0, 2'd2, 8'd2);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h7777;
    step();
    instr_valid = 1'b0; wr_en = 1'b0;
    check("conflict_data1", 32'(data1), 32'h7777);
    check("conflict_data2", 32'(data2), 32'h7777);
    step();

    // Backpressure: A, B held, C stalls, then drain in order
    ready = 1'b0;
    set_instr(4'h1, 1'b0, 1'b0, 2'd0, 8'd1);
    step();
    set_instr(4'h2, 1'b0, 1'b0, 2'd1, 8'd2);
    step();
    check("bp_ready_after_b", 32'(instr_ready), 32'h0);
    set_instr(4'h3, 1'b0, 1'b0, 2'd2, 8'd3);
    step();
    step();
    check("bp_hold_op", 32'(opcode), 32'h1);
    check("bp_hold_ready", 32'(instr_ready), 32'h0);
    seen.delete();
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) instr_valid = 1'b0;
    end
    check("bp_drain_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("bp_order_a", 32'(seen[0]), 32'h1);
      check("bp_order_b", 32'(seen[1]), 32'h2);
      check("bp_order_c", 32'(seen[2]), 32'h3);
    end

    // Accept and consume together while holding one entry
    set_instr(4'h8, 1'b1, 1'b0, 2'd1, 8'h11);
    step();
    set_instr(4'h9, 1'b1, 1'b1, 2'd2, 8'h22);
    step();
    instr_valid = 1'b0;
    check("one_valid", 32'(valid), 32'h1);
    check("one_ready", 32'(instr_ready), 32'h1);
    check("one_opcode", 32'(opcode), 32'h9);
    check("one_data2", 32'(data2), 32'h0022);
    step();

    // Asynchronous reset while full
    ready = 1'b0;
    set_instr(4'hA, 1'b0, 1'b0, 2'd3, 8'd0);
    step();
    set_instr(4'hB, 1'b0, 1'b0, 2'd1, 8'd3);
    step();
    instr_valid = 1'b0;
    check("full_ready", 32'(instr_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_ready", 32'(instr_ready), 32'h1);
    check("arst_opcode", 32'(opcode), 32'h0);
    check("arst_data1", 32'(data1), 32'h0);
    check("arst_data2", 32'(data2), 32'h0);
    check("arst_dest", 32'(dest), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      set_instr(4'h4, 1'b0, 1'b0, 2'(r), 8'(r));
      step();
      check("arst_rf_d1", 32'(data1), 32'h0);
      check("arst_rf_d2", 32'(data2), 32'h0);
    end
    instr_valid = 1'b0;
    step();

    // Random traffic; a presented instruction stays until accepted
    last_acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!(instr_valid && !last_acc)) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr       = 16'($urandom);
      end
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 16'($urandom);
      ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Operand-fetch stage that sits directly upstream of the ALU.
- Accepts a 16-bit instruction word, decodes the opcode and operand fields, and reads the 4x16 register file it owns, with write-through bypass from writeback.
- Presents opcode, shift direction and both operands to the ALU through a registered valid/ready pipeline stage with a 2-entry skid buffer. Upstream ready is therefore a pure register output.

Parameters:
- DATA_W, 16, operand/register width
- NUM_REGS, 4, register file depth (addressed by 2-bit fields)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_instr_valid  in  1  instruction word valid
- o_instr_ready  out  1  stage can accept an instruction
- i_instr  in  16  instruction word
- i_wr_en  in  1  register file write enable (from writeback)
- i_wr_addr  in  2  write register index
- i_wr_data  in  16  write data
- o_valid  out  1  ALU operands valid
- i_ready  in  1  ALU/next stage accepts operands
- o_opcode  out  4  ALU opcode
- o_shift_dir  out  1  0 = right, 1 = left
- o_data1  out  16  operand 1
- o_data2  out  16  operand 2
- o_dest  out  2  destination register index, passed downstream

Behaviour:
- Instruction fields:
  - [15:12] opcode
  - [11] imm_sel
  - [10] shift_dir
  - [9:8] ra, which is both source 1 and destination
  - [7:0] imm8 when imm_sel=1
  - [1:0] rb when imm_sel=0
- Decode:
  - data1 = R[ra]
  - data2 = {8'h00, imm8} when imm_sel=1, else R[rb]
  - opcode, shift_dir and dest = ra are copied unchanged.
  - No opcode-specific decoding is done here.
- Bypass: if i_wr_en=1 and i_wr_addr equals the register being read in the capture cycle, i_wr_data is used instead of the stale register value. This applies to data1 and data2 independently.
- Register file:
  - Written on the rising edge when i_wr_en=1, independent of any handshake state.
  - All registers clear to 0 on reset.
- Accept: an instruction is accepted on the rising edge where i_instr_valid & o_instr_ready.
- Output hand-off: the output entry is consumed on the rising edge where o_valid & i_ready.
- Operands are captured at accept time. A later writeback does not update an entry that is already held.
- Skid-buffer FSM (held entries):
  - EMPTY: o_valid=0, o_instr_ready=1. Accept -> ONE.
  - ONE: o_valid=1, o_instr_ready=1.
    - Accept with no consume -> FULL (new entry goes to skid).
    - Consume with no accept -> EMPTY.
    - Accept and consume together -> ONE, with the new entry in the output register.
  - FULL: o_valid=1, o_instr_ready=0.
    - Consume -> ONE; the skid entry moves to the output register on the same edge.
    - No accept is possible in FULL.
- Latency: one cycle from accept to o_valid when the stage is empty. Throughput is one instruction per cycle while i_ready=1.
- Output stability: output fields stay stable while o_valid=1 and i_ready=0.
- o_instr_ready is a function of state only; there is no combinational path from i_ready.
- Reset (async, any time, including mid-transfer):
  - State -> EMPTY, o_valid=0, o_instr_ready=1.
  - o_opcode, o_shift_dir, o_data1, o_data2, o_dest -> 0.
  - Register file -> 0; skid contents are discarded.
  - o_instr_ready is 1 in the first cycle after reset deassertion.
- Write conflict: i_wr_addr colliding with both ra and rb in the same cycle bypasses to both operands.

Test Plan:
- Basic read:
  - Write R1=16'h1234 and R2=16'h0F0F.
  - Apply instr opcode=4'h0, imm_sel=0, ra=1, rb=2 with i_ready=1.
  - Next cycle: o_valid=1, o_data1=16'h1234, o_data2=16'h0F0F, o_dest=1.
- Immediate:
  - R3=16'h00FF.
  - Instr imm_sel=1, shift_dir=1, ra=3, imm8=8'h04.
  - Required: o_data1=16'h00FF, o_data2=16'h0004, o_shift_dir=1.
- Bypass:
  - In the same cycle as accepting an instr reading R0, drive i_wr_en=1, i_wr_addr=0, i_wr_data=16'hBEEF.
  - Required: o_data1=16'hBEEF.
- Backpressure:
  - Hold i_ready=0 and stream three valid instrs A, B, C.
  - Required: A and B accepted, o_instr_ready=0 after B, C held at input, outputs show A stable.
  - Release i_ready: A, B, C emerge in order on consecutive cycles, with no loss or duplication.
- Simultaneous accept/consume in ONE: state stays ONE, o_valid stays 1, and the output updates to the new entry.
- Reset mid-transfer:
  - Assert i_rst_n=0 asynchronously while in state FULL.
  - Required: o_valid=0 and o_instr_ready=1 immediately, all output fields 0, R0..R3 read back as 0.
